drp_reconf_ctrl: RTL and testbench
==================================

Name: drp_reconf_ctrl

Overview:
Sequencer that drives the DRP port of the PLL model (dyn_reconf) to apply a stored set of register updates.
- Holds a small programmable table of {DRP address, keep-mask, data} entries.
- On a start request it asserts PLL reset and performs read-modify-write on every entry.
- It then releases reset, waits for LOCKED and reports done or error.
- Sits between the system configuration logic and the PLL's DADDR/DEN/DWE/DI/DO/DRDY pins.

Parameters:
N_ENTRIES, 8, number of table entries (1..16); table index width = clog2(N_ENTRIES), minimum 1.
DRDY_TIMEOUT, 64, DCLK cycles allowed between a DEN pulse and DRDY before error.
LOCK_TIMEOUT, 4096, DCLK cycles allowed after PLL reset release for LOCKED before error.

Ports:
DCLK  in  1  clock for all logic.
RSTN  in  1  asynchronous active-low reset.
TBL_WE  in  1  table write strobe; ignored unless BUSY=0.
TBL_IDX  in  clog2(N_ENTRIES)  table write index.
TBL_DATA  in  39  {addr[38:32], keep_mask[31:16], data[15:0]}.
TBL_LEN  in  clog2(N_ENTRIES)+1  number of entries to apply (0 = none).
SEN  in  1  start pulse.
BUSY  out  1  sequence in progress.
SRDY  out  1  one-cycle done pulse.
ERR  out  1  sticky error; cleared on next accepted SEN.
DADDR  out  7  DRP address.
DEN  out  1  DRP enable (one-cycle pulse).
DWE  out  1  DRP write enable, valid with DEN.
DI  out  16  DRP write data.
DO  in  16  DRP read data, valid when DRDY=1.
DRDY  in  1  DRP ready pulse.
LOCKED  in  1  PLL lock indicator.
PLL_RST  out  1  active-high reset to PLL.

Behaviour:
- Reset (RSTN=0, async): state IDLE; BUSY, SRDY, ERR, DEN, DWE, PLL_RST = 0; DADDR, DI = 0; entry index = 0. Table contents are not reset.
- Table write: when TBL_WE=1 and BUSY=0, entry TBL_IDX <= TBL_DATA on the DCLK edge. A write while BUSY=1 is dropped.
- States: IDLE, ASSERT_RST, READ, WAIT_R, WRITE, WAIT_W, [VERIFY, WAIT_V], RELEASE, WAIT_LOCK, DONE.
- IDLE:
  - SEN=1 and TBL_LEN>0: latch TBL_LEN, clear ERR, BUSY=1, go to ASSERT_RST.
  - SEN=1 and TBL_LEN=0: one-cycle SRDY pulse, no DRP traffic.
  - SEN while BUSY is ignored.
- ASSERT_RST: PLL_RST=1 (held until RELEASE); next cycle go to READ.
- READ: DEN=1, DWE=0, DADDR=entry.addr for exactly one cycle; then WAIT_R.
- WAIT_R: on DRDY, DI <= (DO & keep_mask) | (data & ~keep_mask); go to WRITE.
- WRITE: DEN=1, DWE=1, DADDR=entry.addr, DI held, for one cycle; then WAIT_W.
- WAIT_W: on DRDY, if index = len-1 go to RELEASE, else index+1 and go to READ.
- Back-to-back accesses: DEN never reasserts before DRDY of the prior access; minimum 1 idle cycle between accesses.
- RELEASE: PLL_RST=0; lock counter cleared; go to WAIT_LOCK.
- WAIT_LOCK: LOCKED=1 goes to DONE.
- DONE: SRDY=1 for one cycle, BUSY=0; go to IDLE.
- Timeouts:
  - DRDY wait counter resets on each DEN. Reaching DRDY_TIMEOUT sets ERR and aborts to RELEASE, so the PLL is never left in reset.
  - Lock counter reaching LOCK_TIMEOUT sets ERR and goes to DONE.
  - DONE always pulses SRDY, including on error.
- DRDY arriving while not in a wait state is ignored.
- RSTN asserted mid-sequence: immediate IDLE, PLL_RST=0, DEN=0.

Optional Feature:
DRP_VERIFY_EN:
- Defined: after WAIT_W each entry does VERIFY (DEN=1, DWE=0, one cycle) then WAIT_V. On DRDY, DO must equal DI; a mismatch sets ERR but the sequence continues. Timeout rules apply to WAIT_V.
- Undefined: VERIFY and WAIT_V states do not exist; WAIT_W proceeds directly.

Test Plan:
- Reset → all outputs 0. Load entry0 = {7'h08, 16'h1000, 16'h6183}, TBL_LEN=1, SEN. DRP model returns DO=16'hFFFF → read at 7'h08, write DI=16'h7183, PLL_RST high across both accesses, LOCKED raised 10 cycles after release → SRDY pulse, ERR=0.
- TBL_LEN=3 (entries at 7'h08, 7'h09, 7'h14) → 6 DEN pulses in address order, DWE pattern 0,1,0,1,0,1, one DEN outstanding at a time.
- DRP model withholds DRDY → ERR=1 after 64 cycles, PLL_RST drops, SRDY pulses after LOCKED; next SEN clears ERR.
- LOCKED held 0 → ERR=1 and SRDY exactly 4096 cycles after PLL_RST release. SEN and TBL_WE pulsed while BUSY → no effect.
- RSTN pulled low during WAIT_R → PLL_RST=0, BUSY=0 asynchronously. TBL_LEN=0 with SEN → SRDY next cycle, no DEN.
- DRP_VERIFY_EN defined, model corrupts readback → ERR=1; all 3 entries are still written and verified.

Source files
------------

// File: rtl/drp_reconf_ctrl_if.sv
// DRP pin bundle between the reconfiguration sequencer and the PLL.
// The sequencer uses the master modport and the PLL or its model uses the slave modport.
`timescale 1ns/1ps

interface drp_reconf_ctrl_if;
    logic [6:0]  DADDR;
    logic        DEN;
    logic        DWE;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DRDY;
    logic        LOCKED;
    logic        PLL_RST;

    modport master (
        output DADDR, DEN, DWE, DI, PLL_RST,
        input  DO, DRDY, LOCKED
    );

    modport slave (
        input  DADDR, DEN, DWE, DI, PLL_RST,
        output DO, DRDY, LOCKED
    );
endinterface

// File: rtl/drp_reconf_ctrl.sv
// Applies a table of read-modify-write updates to the PLL over DRP, holding the PLL in reset.
// Define DRP_VERIFY_EN to add a read-back check of every written entry.
`timescale 1ns/1ps

module drp_reconf_ctrl #(
    parameter int N_ENTRIES    = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 4096,
    localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
    localparam int LW = IW + 1
) (
    input  logic          DCLK,
    input  logic          RSTN,
    input  logic          TBL_WE,
    input  logic [IW-1:0] TBL_IDX,
    input  logic [38:0]   TBL_DATA,
    input  logic [LW-1:0] TBL_LEN,
    input  logic          SEN,
    output logic          BUSY,
    output logic          SRDY,
    output logic          ERR,
    drp_reconf_ctrl_if.master drp
);

    localparam int CW = $clog2(DRDY_TIMEOUT + LOCK_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ASSERT_RST,
        S_READ,
        S_WAIT_R,
        S_WRITE,
        S_WAIT_W,
`ifdef DRP_VERIFY_EN
        S_VERIFY,
        S_WAIT_V,
`endif
        S_RELEASE,
        S_WAIT_LOCK,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [6:0]    daddr_q, daddr_d;
    logic [15:0]   di_q, di_d;
    logic [38:0]   tbl_q [N_ENTRIES];
    logic [38:0]   cur;
    logic          last_entry;
    logic          drdy_expired;
    logic          advance;

    assign cur          = tbl_q[idx_q];
    assign last_entry   = ({1'b0, idx_q} == len_q - 1'b1);
    assign drdy_expired = (cnt_q == CW'(DRDY_TIMEOUT - 1));

    // Table is configuration storage only; it is deliberately not reset.
    always_ff @(posedge DCLK) begin
        if (TBL_WE && !BUSY && (int'(TBL_IDX) < N_ENTRIES))
            tbl_q[TBL_IDX] <= TBL_DATA;
    end

    always_ff @(posedge DCLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            daddr_q <= '0;
            di_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        daddr_d = daddr_q;
        di_d    = di_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (SEN) begin
                    if (TBL_LEN != '0) begin
                        len_d   = (TBL_LEN > LW'(N_ENTRIES)) ? LW'(N_ENTRIES) : TBL_LEN;
                        idx_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_ASSERT_RST;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ASSERT_RST: state_d = S_READ;
            S_READ: begin
                cnt_d   = '0;
                state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (drp.DRDY) begin
                    di_d    = (drp.DO & cur[31:16]) | (cur[15:0] & ~cur[31:16]);
                    state_d = S_WRITE;
                end else if (drdy_expired) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                cnt_d   = '0;
                state_d = S_WAIT_W;
            end
            S_WAIT_W: begin
                if (drp.DRDY) begin
`ifdef DRP_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    advance = 1'b1;
`endif
                end else if (drdy_expired) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef DRP_VERIFY_EN
            S_VERIFY: begin
                cnt_d   = '0;
                state_d = S_WAIT_V;
            end
            S_WAIT_V: begin
                if (drp.DRDY) begin
                    if (drp.DO != di_q)
                        err_d = 1'b1;
                    advance = 1'b1;
                end else if (drdy_expired) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            // Counter starts at 1 here so it reads cycles elapsed since PLL_RST fell.
            S_RELEASE: begin
                cnt_d   = CW'(1);
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (drp.LOCKED) begin
                    state_d = S_DONE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (last_entry) begin
                state_d = S_RELEASE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = S_READ;
            end
        end

        if (state_d == S_READ)
            daddr_d = tbl_q[idx_d][38:32];
    end

    always_comb begin
        drp.DEN     = 1'b0;
        drp.DWE     = 1'b0;
        drp.PLL_RST = 1'b0;
        case (state_q)
            S_ASSERT_RST, S_WAIT_R, S_WAIT_W: drp.PLL_RST = 1'b1;
            S_READ: begin
                drp.DEN     = 1'b1;
                drp.PLL_RST = 1'b1;
            end
            S_WRITE: begin
                drp.DEN     = 1'b1;
                drp.DWE     = 1'b1;
                drp.PLL_RST = 1'b1;
            end
`ifdef DRP_VERIFY_EN
            S_VERIFY: begin
                drp.DEN     = 1'b1;
                drp.PLL_RST = 1'b1;
            end
            S_WAIT_V: drp.PLL_RST = 1'b1;
`endif
            default: ;
        endcase
    end

    assign drp.DADDR = daddr_q;
    assign drp.DI    = di_q;
    assign BUSY      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign SRDY      = (state_q == S_DONE);
    assign ERR       = err_q;

endmodule

// File: tb/tb_drp_reconf_ctrl.sv
// Scoreboard bench for drp_reconf_ctrl: reference model pushes expected DRP accesses and
// completion status; a monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps

module tb_drp_reconf_ctrl;

    localparam int N       = 8;
    localparam int DRDY_TO = 64;
    localparam int LOCK_TO = 4096;

    localparam int M_NORMAL  = 0;
    localparam int M_DRDY_TO = 1;
    localparam int M_LOCK_TO = 2;
    localparam int M_ABORT   = 3;

    logic        DCLK = 1'b0;
    logic        RSTN;
    logic        TBL_WE;
    logic [2:0]  TBL_IDX;
    logic [38:0] TBL_DATA;
    logic [3:0]  TBL_LEN;
    logic        SEN;
    logic        BUSY, SRDY, ERR;

    drp_reconf_ctrl_if drp_bus();

    drp_reconf_ctrl #(
        .N_ENTRIES(N),
        .DRDY_TIMEOUT(DRDY_TO),
        .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .DCLK(DCLK),
        .RSTN(RSTN),
        .TBL_WE(TBL_WE),
        .TBL_IDX(TBL_IDX),
        .TBL_DATA(TBL_DATA),
        .TBL_LEN(TBL_LEN),
        .SEN(SEN),
        .BUSY(BUSY),
        .SRDY(SRDY),
        .ERR(ERR),
        .drp(drp_bus.master)
    );

    always #5 DCLK = ~DCLK;

    typedef struct {
        bit        we;
        bit [6:0]  addr;
        bit [15:0] di;
    } txn_t;

    txn_t exp_txn[$];
    bit   exp_done[$];
    int   n_cmp = 0;
    int   n_err = 0;

    bit [38:0] ref_tbl [N];
    bit [15:0] ref_mem [128];
    bit        ref_err = 1'b0;
    bit [15:0] slv_mem [128];
    bit        withhold = 1'b0, corrupt = 1'b0, lock_never = 1'b0;
    int        lock_delay = 10;

    int   cyc = 0, rel_cyc = 0, den_cyc = 0, done_cnt = 0, den_cnt = 0;
    bit   outstanding = 1'b0, prev_rst = 1'b0, chk_lock = 1'b0, chk_drdy = 1'b0;
    txn_t mon_t;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: each entry is a read of addr then a write of the merged value.
    function automatic void expect_run(input int len, input int mode);
        txn_t t;
        bit   err = 1'b0;
        if (len == 0) begin
            exp_done.push_back(ref_err);
            return;
        end
        if (mode == M_DRDY_TO || mode == M_ABORT) begin
            t = '{1'b0, ref_tbl[0][38:32], 16'h0};
            exp_txn.push_back(t);
            ref_err = (mode == M_DRDY_TO);
            if (mode == M_DRDY_TO)
                exp_done.push_back(1'b1);
            return;
        end
        for (int i = 0; i < len; i++) begin
            bit [6:0]  a = ref_tbl[i][38:32];
            bit [15:0] k = ref_tbl[i][31:16];
            bit [15:0] d = ref_tbl[i][15:0];
            bit [15:0] nw = (ref_mem[a] & k) | (d & ~k);
            bit [15:0] stored = corrupt ? (nw ^ 16'h0100) : nw;
            t = '{1'b0, a, 16'h0};
            exp_txn.push_back(t);
            t = '{1'b1, a, nw};
            exp_txn.push_back(t);
            ref_mem[a] = stored;
`ifdef DRP_VERIFY_EN
            t = '{1'b0, a, 16'h0};
            exp_txn.push_back(t);
            if (stored != nw)
                err = 1'b1;
`endif
        end
        if (mode == M_LOCK_TO)
            err = 1'b1;
        exp_done.push_back(err);
        ref_err = err;
    endfunction

    // DRP slave: answers each access after 1..4 cycles; writes update its register file.
    initial begin
        bit        pend;
        bit        p_we;
        bit [6:0]  p_addr;
        bit [15:0] p_di;
        int        lat;
        pend = 1'b0;
        drp_bus.DRDY = 1'b0;
        drp_bus.DO   = '0;
        forever begin
            @(negedge DCLK);
            drp_bus.DRDY = 1'b0;
            if (!RSTN) begin
                pend = 1'b0;
            end else if (drp_bus.DEN) begin
                pend   = !withhold;
                p_we   = drp_bus.DWE;
                p_addr = drp_bus.DADDR;
                p_di   = drp_bus.DI;
                lat    = $urandom_range(0, 3);
            end else if (pend) begin
                if (lat == 0) begin
                    drp_bus.DRDY = 1'b1;
                    if (p_we) begin
                        slv_mem[p_addr] = corrupt ? (p_di ^ 16'h0100) : p_di;
                        drp_bus.DO = 16'($urandom);
                    end else begin
                        drp_bus.DO = slv_mem[p_addr];
                    end
                    pend = 1'b0;
                end else begin
                    lat--;
                end
            end
        end
    end

    // PLL: unlocked while held in reset, locks lock_delay cycles after release.
    initial begin
        int lc;
        lc = 0;
        drp_bus.LOCKED = 1'b0;
        forever begin
            @(negedge DCLK);
            if (!RSTN || drp_bus.PLL_RST || lock_never) begin
                drp_bus.LOCKED = 1'b0;
                lc = 0;
            end else if (lc >= lock_delay) begin
                drp_bus.LOCKED = 1'b1;
            end else begin
                lc++;
            end
        end
    end

    always @(posedge DCLK) begin
        #1;
        cyc++;
        if (!RSTN) begin
            outstanding = 1'b0;
            prev_rst    = 1'b0;
        end else begin
            if (drp_bus.DRDY)
                outstanding = 1'b0;
            if (prev_rst && !drp_bus.PLL_RST) begin
                rel_cyc = cyc;
                if (chk_drdy)
                    check("drdy_timeout_cycles", 32'(cyc - den_cyc), 32'(DRDY_TO + 1));
            end
            prev_rst = drp_bus.PLL_RST;
            if (drp_bus.DEN) begin
                den_cnt++;
                den_cyc = cyc;
                check("one_outstanding", 32'(outstanding), 32'd0);
                check("pll_rst_during_den", 32'(drp_bus.PLL_RST), 32'd1);
                outstanding = 1'b1;
                check("den_expected", 32'(exp_txn.size() > 0), 32'd1);
                if (exp_txn.size() > 0) begin
                    mon_t = exp_txn.pop_front();
                    check("den_dwe", 32'(drp_bus.DWE), 32'(mon_t.we));
                    check("den_daddr", 32'(drp_bus.DADDR), 32'(mon_t.addr));
                    if (mon_t.we)
                        check("den_di", 32'(drp_bus.DI), 32'(mon_t.di));
                end
            end
            if (SRDY) begin
                done_cnt++;
                outstanding = 1'b0;
                check("busy_at_srdy", 32'(BUSY), 32'd0);
                if (chk_lock)
                    check("lock_timeout_cycles", 32'(cyc - rel_cyc), 32'(LOCK_TO));
                check("srdy_expected", 32'(exp_done.size() > 0), 32'd1);
                if (exp_done.size() > 0)
                    check("err_at_srdy", 32'(ERR), 32'(exp_done.pop_front()));
            end
        end
    end

    task automatic tbl_write(input int idx, input bit [38:0] d);
        @(negedge DCLK);
        TBL_WE   = 1'b1;
        TBL_IDX  = 3'(idx);
        TBL_DATA = d;
        @(negedge DCLK);
        TBL_WE = 1'b0;
        ref_tbl[idx] = d;
    endtask

    task automatic start_seq(input int len, input int mode);
        expect_run(len, mode);
        @(negedge DCLK);
        TBL_LEN = 4'(len);
        SEN     = 1'b1;
        @(negedge DCLK);
        SEN = 1'b0;
        if (len > 0) begin
            check("busy_after_sen", 32'(BUSY), 32'd1);
            check("err_cleared_by_sen", 32'(ERR), 32'd0);
        end else begin
            check("srdy_len0_next_cycle", 32'(SRDY), 32'd1);
        end
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int c = 0;
        while (done_cnt == start && c < budget) begin
            @(negedge DCLK);
            c++;
        end
        check("srdy_within_budget", 32'(done_cnt != start), 32'd1);
        @(negedge DCLK);
    endtask

    initial begin
        int d0;
        RSTN = 1'b0; TBL_WE = 1'b0; TBL_IDX = '0; TBL_DATA = '0; TBL_LEN = '0; SEN = 1'b0;
        for (int i = 0; i < 128; i++) begin
            slv_mem[i] = 16'($urandom);
            ref_mem[i] = slv_mem[i];
        end
        repeat (3) @(negedge DCLK);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_srdy", 32'(SRDY), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_den", 32'(drp_bus.DEN), 32'd0);
        check("rst_dwe", 32'(drp_bus.DWE), 32'd0);
        check("rst_pll_rst", 32'(drp_bus.PLL_RST), 32'd0);
        check("rst_daddr", 32'(drp_bus.DADDR), 32'd0);
        check("rst_di", 32'(drp_bus.DI), 32'd0);
        @(negedge DCLK);
        RSTN = 1'b1;

        // Single entry against an all-ones register: (FFFF & 1000) | (6183 & EFFF) = 7183.
        slv_mem[8] = 16'hFFFF;
        ref_mem[8] = 16'hFFFF;
        tbl_write(0, {7'h08, 16'h1000, 16'h6183});
        start_seq(1, M_NORMAL);
        wait_done(300);
        check("example_di", 32'(drp_bus.DI), 32'h7183);
        check("example_err", 32'(ERR), 32'd0);

        tbl_write(1, {7'h09, 16'($urandom), 16'($urandom)});
        tbl_write(2, {7'h14, 16'($urandom), 16'($urandom)});
        d0 = den_cnt;
        start_seq(3, M_NORMAL);
        wait_done(400);
`ifdef DRP_VERIFY_EN
        check("den_count_3_entries", 32'(den_cnt - d0), 32'd9);
`else
        check("den_count_3_entries", 32'(den_cnt - d0), 32'd6);
`endif

        withhold = 1'b1;
        chk_drdy = 1'b1;
        start_seq(2, M_DRDY_TO);
        wait_done(500);
        withhold = 1'b0;
        chk_drdy = 1'b0;
        check("err_sticky_after_drdy_timeout", 32'(ERR), 32'd1);
        start_seq(1, M_NORMAL);
        wait_done(300);

        lock_never = 1'b1;
        chk_lock   = 1'b1;
        start_seq(2, M_LOCK_TO);
        repeat (30) @(negedge DCLK);
        check("busy_before_ignored_sen", 32'(BUSY), 32'd1);
        SEN = 1'b1; TBL_LEN = 4'd5; TBL_WE = 1'b1; TBL_IDX = 3'd0; TBL_DATA = 39'h7F_FFFF_FFFF;
        @(negedge DCLK);
        SEN = 1'b0; TBL_WE = 1'b0;
        wait_done(LOCK_TO + 200);
        lock_never = 1'b0;
        chk_lock   = 1'b0;
        check("err_after_lock_timeout", 32'(ERR), 32'd1);
        start_seq(1, M_NORMAL);
        wait_done(300);

        withhold = 1'b1;
        d0 = den_cnt;
        start_seq(3, M_ABORT);
        for (int c = 0; c < 20 && den_cnt == d0; c++)
            @(negedge DCLK);
        check("abort_read_issued", 32'(den_cnt - d0), 32'd1);
        repeat (2) @(negedge DCLK);
        #2;
        RSTN = 1'b0;
        #1;
        check("async_rst_pll_rst", 32'(drp_bus.PLL_RST), 32'd0);
        check("async_rst_busy", 32'(BUSY), 32'd0);
        check("async_rst_den", 32'(drp_bus.DEN), 32'd0);
        check("abort_txn_consumed", 32'(exp_txn.size()), 32'd0);
        exp_txn.delete();
        exp_done.delete();
        withhold = 1'b0;
        repeat (2) @(negedge DCLK);
        RSTN = 1'b1;

        d0 = den_cnt;
        start_seq(0, M_NORMAL);
        @(negedge DCLK);
        check("len0_no_den", 32'(den_cnt - d0), 32'd0);

`ifdef DRP_VERIFY_EN
        corrupt = 1'b1;
        tbl_write(0, {7'h21, 16'($urandom), 16'($urandom)});
        tbl_write(1, {7'h22, 16'($urandom), 16'($urandom)});
        tbl_write(2, {7'h23, 16'($urandom), 16'($urandom)});
        d0 = den_cnt;
        start_seq(3, M_NORMAL);
        wait_done(500);
        corrupt = 1'b0;
        check("verify_den_count", 32'(den_cnt - d0), 32'd9);
        check("verify_err", 32'(ERR), 32'd1);
`endif

        for (int r = 0; r < 8; r++) begin
            int nw = $urandom_range(1, 3);
            for (int w = 0; w < nw; w++)
                tbl_write($urandom_range(0, N - 1), 39'({$urandom, $urandom}));
            lock_delay = $urandom_range(0, 20);
            start_seq($urandom_range(1, N), M_NORMAL);
            wait_done(800);
        end

        check("txn_queue_drained", 32'(exp_txn.size()), 32'd0);
        check("done_queue_drained", 32'(exp_done.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit (%0d compared / %0d mismatched so far)", n_cmp, n_err);
        $fatal(1);
    end

endmodule
